i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 141 ++++++++++++++
 tb/tb_i2c_target.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// i2c_target: I2C target that ACKs its 7-bit address, receives write bytes and serves read bytes.
module i2c_target #(
   parameter logic [6:0] DEV_ADDR = 7'h42
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy
);
   typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} state_t;
   state_t state_q, state_d;
   logic [2:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d, cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
   logic oe_q, oe_d, rw_q, rw_d, ack_q, ack_d, busy_q, busy_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
   logic scl_s, sda_s, scl_rise, scl_fall, start, stop;
   assign scl_s    = scl_sync_q[1];
   assign sda_s    = sda_sync_q[1];
   assign scl_rise = scl_s & ~scl_sync_q[2];
   assign scl_fall = ~scl_s & scl_sync_q[2];
   assign start    = scl_s & ~sda_s & sda_sync_q[2];
   assign stop     = scl_s & sda_s & ~sda_sync_q[2];
   assign sda      = oe_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;
   // Next-state: START/STOP override everything; otherwise the protocol FSM advances on scl edges.
   always_comb begin
      scl_sync_d = {scl_sync_q[1:0], scl};
      sda_sync_d = {sda_sync_q[1:0], sda};
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      oe_d       = oe_q;
      rw_d       = rw_q;
      ack_d      = ack_q;
      busy_d     = busy_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      if (start) begin
         state_d = ADDR;
         oe_d    = 1'b0;
         cnt_d   = 3'd0;
         busy_d  = 1'b0;
      end else if (stop) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         cnt_d   = 3'd0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shift_d = {shift_q[6:0], sda_s};
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  rw_d    = sda_s;
                  state_d = (shift_q[6:0] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                  busy_d  = (shift_q[6:0] == DEV_ADDR);
               end
            end
            ADDR_ACK, WR_ACK: if (scl_fall) begin
               if (!oe_q) oe_d = 1'b1;
               else begin
                  oe_d     = 1'b0;
                  tx_req_d = (state_q == ADDR_ACK) && rw_q;
                  state_d  = ((state_q == ADDR_ACK) && rw_q) ? RD_BYTE : WR_BYTE;
               end
            end
            WR_BYTE: if (scl_rise) begin
               shift_d = {shift_q[6:0], sda_s};
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  rx_data_d  = {shift_q[6:0], sda_s};
                  rx_valid_d = 1'b1;
                  state_d    = WR_ACK;
               end
            end
            RD_BYTE: if (tx_req_q) begin
               shift_d = tx_data;
               oe_d    = ~tx_data[7];
            end else if (scl_fall) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  oe_d    = 1'b0;
                  ack_d   = 1'b0;
                  state_d = RD_ACK;
               end else begin
                  shift_d = {shift_q[6:0], 1'b0};
                  oe_d    = ~shift_q[6];
               end
            end
            RD_ACK: if (scl_rise) begin
               ack_d   = ~sda_s;
               state_d = sda_s ? IGNORE : RD_ACK;
               busy_d  = ~sda_s;
            end else if (scl_fall && ack_q) begin
               ack_d    = 1'b0;
               tx_req_d = 1'b1;
               state_d  = RD_BYTE;
            end
            default: ;
         endcase
      end
   end
   // State and registered outputs; reset releases sda immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
         cnt_q      <= 3'd0;
         shift_q    <= 8'h00;
         rx_data_q  <= 8'h00;
         oe_q       <= 1'b0;
         rw_q       <= 1'b0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         oe_q       <= oe_d;
         rw_q       <= rw_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
      end
   end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-master bench for i2c_target with hand-computed expectations.
module tb_i2c_target;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       m_low = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] rx_data;
   logic       rx_valid, tx_req, busy;
   wire        sda;
   int         tests = 0, fails = 0;
   int         rx_cnt = 0, tx_cnt = 0, coll_cnt = 0, busy_cnt = 0, drv_cnt = 0;
   int         rx0, tx0, busy0, drv0;
   logic       ack, r;
   logic [7:0] d;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_target #(.DEV_ADDR(7'h42)) dut (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
   );

   always #5 clk = ~clk;

   // Pulse and bus-drive counters used by the directed checks.
   always @(posedge clk) begin
      if (rx_valid) rx_cnt++;
      if (tx_req) tx_cnt++;
      if (rx_valid && tx_req) coll_cnt++;
      if (busy) busy_cnt++;
      if (!m_low && sda == 1'b0) drv_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_cycle(input logic b, output logic rb);
      m_low = ~b;
      clks(6);
      scl = 1'b1;
      clks(3);
      rb = sda;
      clks(3);
      scl = 1'b0;
      clks(2);
   endtask

   task automatic bus_start();
      m_low = 1'b0;
      clks(4);
      scl = 1'b1;
      clks(6);
      m_low = 1'b1;
      clks(6);
      scl = 1'b0;
      clks(2);
   endtask

   task automatic bus_stop();
      m_low = 1'b1;
      clks(4);
      scl = 1'b1;
      clks(6);
      m_low = 1'b0;
      clks(6);
   endtask

   task automatic write_byte(input logic [7:0] v, output logic acked);
      logic x;
      for (int i = 7; i >= 0; i--) bit_cycle(v[i], x);
      bit_cycle(1'b1, x);
      acked = ~x;
   endtask

   task automatic read_byte(output logic [7:0] v, input logic m_ack);
      logic x;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(1'b1, x);
         v[i] = x;
      end
      bit_cycle(~m_ack, x);
   endtask

   initial begin
      clks(3);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_tx_req", tx_req, 0);
      check("rst_busy", busy, 0);
      check("rst_sda", sda, 1);
      rst = 1'b0;
      clks(4);

      // write 0xA5 to 0x42
      rx0 = rx_cnt; tx0 = tx_cnt;
      bus_start();
      write_byte(8'h84, ack);
      check("wr_addr_ack", ack, 1);
      check("wr_busy", busy, 1);
      write_byte(8'hA5, ack);
      check("wr_data_ack", ack, 1);
      check("wr_rx_valid_cnt", rx_cnt - rx0, 1);
      check("wr_rx_data", rx_data, 8'hA5);
      bus_stop();
      clks(4);
      check("wr_busy_after_stop", busy, 0);
      check("wr_no_tx_req", tx_cnt - tx0, 0);

      // address 0x43: ignored
      rx0 = rx_cnt; busy0 = busy_cnt; drv0 = drv_cnt;
      bus_start();
      write_byte(8'h86, ack);
      check("miss_addr_nack", ack, 0);
      write_byte(8'h55, ack);
      check("miss_data_nack", ack, 0);
      bus_stop();
      clks(4);
      check("miss_rx_valid_cnt", rx_cnt - rx0, 0);
      check("miss_busy_cnt", busy_cnt - busy0, 0);
      check("miss_sda_driven", drv_cnt - drv0, 0);

      // read 0x3C (ACK) then 0xC1 (NACK)
      tx0 = tx_cnt;
      tx_data = 8'h3C;
      bus_start();
      write_byte(8'h85, ack);
      check("rd_addr_ack", ack, 1);
      read_byte(d, 1'b1);
      check("rd_byte0", d, 8'h3C);
      tx_data = 8'hC1;
      read_byte(d, 1'b0);
      check("rd_byte1", d, 8'hC1);
      clks(6);
      check("rd_tx_req_cnt", tx_cnt - tx0, 2);
      check("rd_busy_after_nack", busy, 0);
      check("rd_sda_released", sda, 1);
      bus_stop();
      clks(4);

      // write 0x10, repeated START, read
      rx0 = rx_cnt; tx0 = tx_cnt;
      bus_start();
      write_byte(8'h84, ack);
      check("rs_wr_addr_ack", ack, 1);
      write_byte(8'h10, ack);
      check("rs_wr_data_ack", ack, 1);
      bus_start();
      check("rs_busy_cleared", busy, 0);
      check("rs_rx_valid_cnt", rx_cnt - rx0, 1);
      check("rs_rx_data", rx_data, 8'h10);
      write_byte(8'h85, ack);
      check("rs_rd_addr_ack", ack, 1);
      clks(8);
      check("rs_tx_req_cnt", tx_cnt - tx0, 1);
      read_byte(d, 1'b0);
      check("rs_rd_byte", d, 8'hC1);
      bus_stop();
      clks(4);

      // STOP after 4 data bits
      rx0 = rx_cnt;
      bus_start();
      write_byte(8'h84, ack);
      check("part_addr_ack", ack, 1);
      bit_cycle(1'b1, r);
      bit_cycle(1'b0, r);
      bit_cycle(1'b1, r);
      bit_cycle(1'b0, r);
      bus_stop();
      clks(4);
      check("part_rx_valid_cnt", rx_cnt - rx0, 0);
      check("part_busy", busy, 0);
      check("part_sda", sda, 1);
      write_byte(8'h84, ack);
      check("part_idle_no_ack", ack, 0);
      check("part_rx_idle", rx_cnt - rx0, 0);

      // reset while driving ACK
      bus_stop();
      clks(4);
      bus_start();
      for (int i = 7; i >= 0; i--) bit_cycle(((8'h84 >> i) & 8'h01) != 0, r);
      m_low = 1'b0;
      clks(6);
      check("rst_ack_driven", sda, 0);
      rst = 1'b1;
      #1;
      check("rst_sda_released", sda, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_rx_data", rx_data, 8'h00);
      check("rst_mid_rx_valid", rx_valid, 0);
      check("rst_mid_tx_req", tx_req, 0);
      clks(2);
      rst = 1'b0;
      rx0 = rx_cnt; drv0 = drv_cnt;
      write_byte(8'h84, ack);
      check("post_rst_no_ack", ack, 0);
      check("post_rst_no_drive", drv_cnt - drv0, 0);
      check("post_rst_rx", rx_cnt - rx0, 0);
      bus_stop();
      clks(4);
      bus_start();
      write_byte(8'h84, ack);
      check("post_rst_start_ack", ack, 1);
      bus_stop();
      clks(4);
      check("no_rx_tx_overlap", coll_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
